fpu_arbiter: RTL and testbench
==============================

FPU_ARBITER -- requirements
Module: fpu_arbiter

Interface
REQ-001 SHALL take parameter NREQ, default 2, giving the number of requesters sharing one fpu (2..4).
REQ-002 SHALL take parameter TIMEOUT, default 64, giving the maximum number of ISSUE cycles before abort (used only under FPU_ARB_TIMEOUT_EN).
REQ-003 SHALL have port clk, input, 1: sole clock, rising edge.
REQ-004 SHALL have port rst, input, 1: asynchronous reset, active-high.
REQ-005 SHALL have port req_valid, input, NREQ: per-requester command request.
REQ-006 SHALL have port req_ready, output, NREQ: one-cycle accept pulse to the granted requester.
REQ-007 SHALL have ports req_x1, req_x2 and req_y, input, NREQx5 each: register indices.
REQ-008 SHALL have port req_op, input, NREQx6: fpu operation code.
REQ-009 SHALL have port req_data, input, NREQx32: in_data operand.
REQ-010 SHALL have port rsp_valid, output, NREQ: one-cycle completion pulse to the owner.
REQ-011 SHALL have ports rsp_data1 (output, 1), rsp_data32 (output, 32) and rsp_err (output, 1): captured result, broadcast to all requesters and qualified by rsp_valid.
REQ-012 SHALL have ports fpu_x1, fpu_x2 and fpu_y (output, 5 each), fpu_operation (output, 6), fpu_in_data (output, 32) and fpu_ready (output, 1): command to the fpu.
REQ-013 SHALL have ports fpu_valid (input, 1), fpu_out_data1 (input, 1) and fpu_out_data32 (input, 32): fpu response.

Function
REQ-014 SHALL implement states IDLE, ISSUE and RESP, one-hot encoded.
REQ-015 IDLE: if any req_valid is high, SHALL grant the first set bit searching upward from rr_ptr (round-robin, wrapping), pulse that requester's req_ready for 1 cycle, latch its x1/x2/y/op/data into command registers, record the owner index, and go to ISSUE.
REQ-016 ISSUE: SHALL drive fpu_ready=1 and the fpu_* command fields from the latched registers, holding them stable every cycle until fpu_valid.
REQ-017 ISSUE with fpu_valid=1: SHALL capture fpu_out_data1 and fpu_out_data32 into rsp_data1 and rsp_data32, set rsp_err=0, and go to RESP.
REQ-018 RESP: SHALL drive fpu_ready=0, pulse rsp_valid[owner] for exactly 1 cycle, set rr_ptr=(owner+1) mod NREQ, and go to IDLE.
REQ-019 fpu_ready SHALL be 1 only in ISSUE, so the fpu sees one deasserted cycle between commands.
REQ-020 Zero-latency ops (MOV/SET/GET, fpu_valid in the first ISSUE cycle) SHALL complete in 3 cycles, counted from the req_ready pulse to the rsp_valid pulse inclusive.
REQ-021 Multi-cycle ops SHALL take (ISSUE cycles + 2) cycles.
REQ-022 SHALL accept at most one outstanding command; req_valid seen in ISSUE or RESP SHALL be ignored and not lost, because requesters hold req_valid until req_ready.
REQ-023 SHALL never grant a requester whose req_valid is low; with no requests, SHALL remain in IDLE with all pulses low.
REQ-024 rsp_data1, rsp_data32 and rsp_err SHALL hold their value until the next capture.

Reset
REQ-025 rst=1 SHALL asynchronously force state=IDLE, rr_ptr=0, req_ready=0, rsp_valid=0, rsp_data1=0, rsp_data32=0, rsp_err=0, fpu_ready=0, command registers=0 and timeout counter=0.
REQ-026 Reset asserted mid-ISSUE SHALL drop the in-flight command with no rsp_valid; the fpu SHALL be reset by the same system reset.

Configuration
REQ-027 With FPU_ARB_TIMEOUT_EN defined, a counter SHALL clear on entry to ISSUE and increment each ISSUE cycle.
REQ-028 With FPU_ARB_TIMEOUT_EN defined, if the counter reaches TIMEOUT-1 without fpu_valid, SHALL go to RESP with rsp_err=1, rsp_data1=0 and rsp_data32=0.
REQ-029 With FPU_ARB_TIMEOUT_EN defined, if fpu_valid and the limit coincide in the same cycle, fpu_valid SHALL win and rsp_err SHALL be 0.
REQ-030 Without FPU_ARB_TIMEOUT_EN, the counter SHALL be absent, rsp_err SHALL be tied to 0, and ISSUE SHALL wait indefinitely.

Structure
REQ-031 A shared package fpu_pkg SHALL hold the 6-bit operation codes (FNEG 010000, FADD 000000, FSUB 000001, FMUL 000010, FCLT 100000, FTOI 111000, ITOF 111001, MOV 111101, SET 111110, GET 111111) and the arbiter state enum.
REQ-032 Round-robin selection SHALL be one combinational sub-module rr_pick (inputs: request vector and pointer; outputs: grant index and any-request).

Verification
REQ-033 Bench SHALL cover: single requester 0 issues SET y=3 data=0x3F800000 with fpu_valid in the first ISSUE cycle -> req_ready[0] at T, fpu_ready at T+1, rsp_valid[0] at T+2, rsp_err=0.
REQ-034 Bench SHALL cover: requesters 0 and 1 both request continuously from reset -> grants alternate 0,1,0,1 and no requester receives two consecutive grants.
REQ-035 Bench SHALL cover: requester 1 issues FADD and the fpu model returns fpu_valid after 4 ISSUE cycles with out_data32=0x40400000 -> fpu_ready high exactly 4 cycles, then low, and rsp_data32=0x40400000 with rsp_valid[1].
REQ-036 Bench SHALL cover: FCLT with fpu_out_data1=1 -> rsp_data1=1; a following GET returning 0x12345678 -> rsp_data32=0x12345678 and rsp_data1 updated to the GET capture.
REQ-037 Bench SHALL cover: rst pulsed in the 2nd ISSUE cycle -> all outputs 0 within the same cycle and no rsp_valid; next request granted from requester 0.
REQ-038 Bench SHALL cover, with FPU_ARB_TIMEOUT_EN and TIMEOUT=8, an fpu model that never asserts valid -> after 8 ISSUE cycles, rsp_valid[owner]=1, rsp_err=1 and rsp_data32=0.

Source files
------------

// File: rtl/fpu_pkg.sv
// Shared FPU definitions: operation codes, arbiter state encoding and the
// latched command payload handed from a requester to the fpu.
package fpu_pkg;

  localparam int unsigned REG_W  = 5;
  localparam int unsigned OP_W   = 6;
  localparam int unsigned DATA_W = 32;

  typedef logic [OP_W-1:0] fpu_op_t;

  localparam fpu_op_t OP_FADD = 6'b000000;
  localparam fpu_op_t OP_FSUB = 6'b000001;
  localparam fpu_op_t OP_FMUL = 6'b000010;
  localparam fpu_op_t OP_FNEG = 6'b010000;
  localparam fpu_op_t OP_FCLT = 6'b100000;
  localparam fpu_op_t OP_FTOI = 6'b111000;
  localparam fpu_op_t OP_ITOF = 6'b111001;
  localparam fpu_op_t OP_MOV  = 6'b111101;
  localparam fpu_op_t OP_SET  = 6'b111110;
  localparam fpu_op_t OP_GET  = 6'b111111;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'b001,
    ST_ISSUE = 3'b010,
    ST_RESP  = 3'b100
  } arb_state_e;

  typedef struct packed {
    logic [REG_W-1:0]  x1;
    logic [REG_W-1:0]  x2;
    logic [REG_W-1:0]  y;
    fpu_op_t           op;
    logic [DATA_W-1:0] data;
  } fpu_cmd_t;

endpackage

// File: rtl/fpu_arbiter_if.sv
// Requester-side and fpu-side signals of the fpu arbiter. The arbiter uses the
// slave modport; requesters plus the fpu together form the master side.
interface fpu_arbiter_if #(parameter int unsigned NREQ = 2);

  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ-1:0][4:0]  req_x1;
  logic [NREQ-1:0][4:0]  req_x2;
  logic [NREQ-1:0][4:0]  req_y;
  logic [NREQ-1:0][5:0]  req_op;
  logic [NREQ-1:0][31:0] req_data;

  logic [NREQ-1:0]       rsp_valid;
  logic                  rsp_data1;
  logic [31:0]           rsp_data32;
  logic                  rsp_err;

  logic [4:0]            fpu_x1;
  logic [4:0]            fpu_x2;
  logic [4:0]            fpu_y;
  logic [5:0]            fpu_operation;
  logic [31:0]           fpu_in_data;
  logic                  fpu_ready;
  logic                  fpu_valid;
  logic                  fpu_out_data1;
  logic [31:0]           fpu_out_data32;

  modport slave (
    input  req_valid, req_x1, req_x2, req_y, req_op, req_data,
    input  fpu_valid, fpu_out_data1, fpu_out_data32,
    output req_ready, rsp_valid, rsp_data1, rsp_data32, rsp_err,
    output fpu_x1, fpu_x2, fpu_y, fpu_operation, fpu_in_data, fpu_ready
  );

  modport master (
    output req_valid, req_x1, req_x2, req_y, req_op, req_data,
    output fpu_valid, fpu_out_data1, fpu_out_data32,
    input  req_ready, rsp_valid, rsp_data1, rsp_data32, rsp_err,
    input  fpu_x1, fpu_x2, fpu_y, fpu_operation, fpu_in_data, fpu_ready
  );

endinterface

// File: rtl/fpu_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr_i,
// wrapping past NREQ-1 back to 0.
module rr_pick #(
  parameter int unsigned NREQ  = 2,
  parameter int unsigned IDX_W = 1
) (
  input  logic [NREQ-1:0]  req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [IDX_W-1:0] gnt_idx_c_o,
  output logic             any_c_o
);

  logic [IDX_W-1:0] pos;

  always_comb begin
    gnt_idx_c_o = '0;
    any_c_o     = 1'b0;
    pos         = '0;
    for (int k = 0; k < int'(NREQ); k++) begin
      pos = IDX_W'((32'(ptr_i) + 32'(k)) % NREQ);
      if (!any_c_o && req_i[pos]) begin
        any_c_o     = 1'b1;
        gnt_idx_c_o = pos;
      end
    end
  end

endmodule

// File: rtl/fpu_arbiter.sv
// Shares one fpu between NREQ requesters, one command in flight at a time.
// Define FPU_ARB_TIMEOUT_EN to abort commands the fpu never answers.
module fpu_arbiter
  import fpu_pkg::*;
#(
  parameter int unsigned NREQ    = 2,
  parameter int unsigned TIMEOUT = 64
) (
  input logic          clk,
  input logic          rst,
  fpu_arbiter_if.slave bus
);

  localparam int unsigned IDX_W = $clog2(NREQ);

  if (NREQ < 2 || NREQ > 4 || TIMEOUT < 2) begin : g_cfg_check
    $error("fpu_arbiter: NREQ must be 2..4 and TIMEOUT at least 2");
  end

  arb_state_e       state_q;
  logic [IDX_W-1:0] rr_ptr_q;
  logic [IDX_W-1:0] owner_q;
  fpu_cmd_t         cmd_q;
  logic [NREQ-1:0]  req_ready_q;
  logic [NREQ-1:0]  rsp_valid_q;
  logic             rsp_data1_q;
  logic [31:0]      rsp_data32_q;
  logic             fpu_ready_q;
  logic [IDX_W-1:0] gnt_idx;
  logic             gnt_any;

`ifdef FPU_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT);
  logic [CNT_W-1:0] cnt_q;
  logic             rsp_err_q;
  logic             limit_c;
  assign limit_c = (cnt_q == CNT_W'(TIMEOUT - 1));
`endif

  rr_pick #(.NREQ(NREQ), .IDX_W(IDX_W)) u_rr_pick (
    .req_i      (bus.req_valid),
    .ptr_i      (rr_ptr_q),
    .gnt_idx_c_o(gnt_idx),
    .any_c_o    (gnt_any)
  );

  // The accept cycle (req_ready high) is the first ISSUE cycle; fpu_ready
  // follows from the next cycle, so the fpu only ever sees a latched command.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      rr_ptr_q     <= '0;
      owner_q      <= '0;
      cmd_q        <= '0;
      req_ready_q  <= '0;
      rsp_valid_q  <= '0;
      rsp_data1_q  <= 1'b0;
      rsp_data32_q <= '0;
      fpu_ready_q  <= 1'b0;
`ifdef FPU_ARB_TIMEOUT_EN
      cnt_q        <= '0;
      rsp_err_q    <= 1'b0;
`endif
    end else begin
      req_ready_q <= '0;
      rsp_valid_q <= '0;
      unique case (state_q)
        ST_IDLE: begin
          if (gnt_any) begin
            state_q     <= ST_ISSUE;
            req_ready_q <= NREQ'(1) << gnt_idx;
            owner_q     <= gnt_idx;
            cmd_q       <= '{x1:   bus.req_x1[gnt_idx],
                             x2:   bus.req_x2[gnt_idx],
                             y:    bus.req_y[gnt_idx],
                             op:   bus.req_op[gnt_idx],
                             data: bus.req_data[gnt_idx]};
`ifdef FPU_ARB_TIMEOUT_EN
            cnt_q       <= '0;
`endif
          end
        end
        ST_ISSUE: begin
          if (fpu_ready_q && bus.fpu_valid) begin
            state_q      <= ST_RESP;
            fpu_ready_q  <= 1'b0;
            rsp_valid_q  <= NREQ'(1) << owner_q;
            rsp_data1_q  <= bus.fpu_out_data1;
            rsp_data32_q <= bus.fpu_out_data32;
`ifdef FPU_ARB_TIMEOUT_EN
            rsp_err_q    <= 1'b0;
          end else if (fpu_ready_q && limit_c) begin
            state_q      <= ST_RESP;
            fpu_ready_q  <= 1'b0;
            rsp_valid_q  <= NREQ'(1) << owner_q;
            rsp_data1_q  <= 1'b0;
            rsp_data32_q <= '0;
            rsp_err_q    <= 1'b1;
`endif
          end else begin
            fpu_ready_q <= 1'b1;
`ifdef FPU_ARB_TIMEOUT_EN
            if (fpu_ready_q) cnt_q <= cnt_q + CNT_W'(1);
`endif
          end
        end
        ST_RESP: begin
          state_q  <= ST_IDLE;
          rr_ptr_q <= IDX_W'((32'(owner_q) + 32'd1) % NREQ);
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.req_ready     = req_ready_q;
  assign bus.rsp_valid     = rsp_valid_q;
  assign bus.rsp_data1     = rsp_data1_q;
  assign bus.rsp_data32    = rsp_data32_q;
  assign bus.fpu_x1        = cmd_q.x1;
  assign bus.fpu_x2        = cmd_q.x2;
  assign bus.fpu_y         = cmd_q.y;
  assign bus.fpu_operation = cmd_q.op;
  assign bus.fpu_in_data   = cmd_q.data;
  assign bus.fpu_ready     = fpu_ready_q;
`ifdef FPU_ARB_TIMEOUT_EN
  assign bus.rsp_err       = rsp_err_q;
`else
  assign bus.rsp_err       = 1'b0;
`endif

endmodule

// File: tb/tb_fpu_arbiter.sv
// Self-checking bench for fpu_arbiter: directed scenarios plus a randomized
// phase scored against a transaction-level round-robin / latency model.
module tb_fpu_arbiter;
  import fpu_pkg::*;

  localparam int unsigned NREQ    = 3;
  localparam int unsigned TIMEOUT = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fpu_arbiter_if #(.NREQ(NREQ)) bus ();
  fpu_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int fpu_lat  = 1;
  int fpu_cnt  = 0;
  int model_ptr = 0;
  logic [NREQ-1:0] valid_at_edge;
  logic [NREQ-1:0] hold_mask;
  logic [4:0]  c_x1 [NREQ];
  logic [4:0]  c_x2 [NREQ];
  logic [4:0]  c_y  [NREQ];
  logic [5:0]  c_op [NREQ];
  logic [31:0] c_data [NREQ];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NREQ-1:0] oh(input int i);
    logic [NREQ-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  // Round-robin reference: first pending requester at or after ptr, wrapping.
  function automatic int rr_model(input logic [NREQ-1:0] v, input int ptr);
    for (int k = 0; k < int'(NREQ); k++)
      if (v[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
    return -1;
  endfunction

  // One clock; requesters drop valid on accept, fpu answers on its lat-th ready cycle.
  task automatic step();
    valid_at_edge = bus.req_valid;
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < int'(NREQ); i++)
      if (bus.req_ready[i] && !hold_mask[i]) bus.req_valid[i] = 1'b0;
    if (bus.fpu_ready) fpu_cnt++; else fpu_cnt = 0;
    bus.fpu_valid = bus.fpu_ready && (fpu_cnt == fpu_lat);
  endtask

  task automatic request(input int i, input logic [5:0] op, input logic [4:0] x1,
                         input logic [4:0] x2, input logic [4:0] y, input logic [31:0] d);
    c_x1[i] = x1; c_x2[i] = x2; c_y[i] = y; c_op[i] = op; c_data[i] = d;
    bus.req_x1[i] = x1; bus.req_x2[i] = x2; bus.req_y[i] = y;
    bus.req_op[i] = op; bus.req_data[i] = d;
    bus.req_valid[i] = 1'b1;
  endtask

  task automatic check_zero(input string t);
    check({t, "_req_ready"}, 64'(bus.req_ready), 0);
    check({t, "_rsp_valid"}, 64'(bus.rsp_valid), 0);
    check({t, "_rsp_data1"}, 64'(bus.rsp_data1), 0);
    check({t, "_rsp_data32"}, 64'(bus.rsp_data32), 0);
    check({t, "_rsp_err"}, 64'(bus.rsp_err), 0);
    check({t, "_fpu_ready"}, 64'(bus.fpu_ready), 0);
    check({t, "_fpu_x1"}, 64'(bus.fpu_x1), 0);
    check({t, "_fpu_x2"}, 64'(bus.fpu_x2), 0);
    check({t, "_fpu_y"}, 64'(bus.fpu_y), 0);
    check({t, "_fpu_op"}, 64'(bus.fpu_operation), 0);
    check({t, "_fpu_in_data"}, 64'(bus.fpu_in_data), 0);
  endtask

  task automatic do_reset();
    bus.req_valid = '0;
    bus.fpu_valid = 1'b0;
    hold_mask = '0;
    fpu_cnt = 0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    rst = 1'b0;
    model_ptr = 0;
  endtask

  task automatic drain(input int n);
    bus.req_valid = '0;
    fpu_lat = 1;
    repeat (n) step();
  endtask

  // Single command from an idle arbiter, checked end to end.
  task automatic run_txn(input string t, input int i, input logic [5:0] op,
                         input logic [4:0] x1, input logic [4:0] x2, input logic [4:0] y,
                         input logic [31:0] d, input int lat, input logic d1,
                         input logic [31:0] d32, input logic exp_err);
    int t_req, t_g, t_first, n_issue, w, exp_issue;
    exp_issue = exp_err ? int'(TIMEOUT) : lat;
    fpu_lat = lat;
    bus.fpu_out_data1 = d1;
    bus.fpu_out_data32 = d32;
    request(i, op, x1, x2, y, d);
    t_req = cyc;
    w = 0;
    step();
    while (bus.req_ready == '0 && w < 50) begin step(); w++; end
    t_g = cyc;
    check({t, "_grant"}, 64'(bus.req_ready), 64'(oh(i)));
    check({t, "_grant_delay"}, 64'(t_g - t_req), 1);
    check({t, "_ready_low_at_grant"}, 64'(bus.fpu_ready), 0);
    n_issue = 0; t_first = 0; w = 0;
    step();
    while (bus.rsp_valid == '0 && w < 200) begin
      if (bus.fpu_ready) begin
        n_issue++;
        if (n_issue == 1) begin
          t_first = cyc;
          check({t, "_fpu_x1"}, 64'(bus.fpu_x1), 64'(c_x1[i]));
          check({t, "_fpu_x2"}, 64'(bus.fpu_x2), 64'(c_x2[i]));
          check({t, "_fpu_y"}, 64'(bus.fpu_y), 64'(c_y[i]));
          check({t, "_fpu_op"}, 64'(bus.fpu_operation), 64'(c_op[i]));
          check({t, "_fpu_in_data"}, 64'(bus.fpu_in_data), 64'(c_data[i]));
        end
      end
      step();
      w++;
    end
    check({t, "_first_issue"}, 64'(t_first - t_g), 1);
    check({t, "_issue_cycles"}, 64'(n_issue), 64'(exp_issue));
    check({t, "_latency"}, 64'(cyc - t_g + 1), 64'(exp_issue + 2));
    check({t, "_rsp_owner"}, 64'(bus.rsp_valid), 64'(oh(i)));
    check({t, "_rsp_ready_low"}, 64'(bus.fpu_ready), 0);
    check({t, "_rsp_err"}, 64'(bus.rsp_err), 64'(exp_err));
    check({t, "_rsp_data1"}, 64'(bus.rsp_data1), exp_err ? 64'd0 : 64'(d1));
    check({t, "_rsp_data32"}, 64'(bus.rsp_data32), exp_err ? 64'd0 : 64'(d32));
    step();
    check({t, "_rsp_pulse"}, 64'(bus.rsp_valid), 0);
    model_ptr = (i + 1) % NREQ;
  endtask

  initial begin
    int grants, n, owner, t_g, lat_cur, issue_n, n_txn, e;
    logic exp_d1;
    logic [31:0] exp_d32;
    logic [4:0] g_x1, g_x2, g_y;
    logic [5:0] g_op;
    logic [31:0] g_data;

    bus.req_valid = '0; bus.req_x1 = '0; bus.req_x2 = '0; bus.req_y = '0;
    bus.req_op = '0; bus.req_data = '0;
    bus.fpu_valid = 1'b0; bus.fpu_out_data1 = 1'b0; bus.fpu_out_data32 = '0;
    hold_mask = '0;
    #1;
    do_reset();
    step();
    check("idle_no_grant", 64'(bus.req_ready), 0);

    // zero-latency SET, then multi-cycle FADD, then FCLT/GET captures
    run_txn("set", 0, OP_SET, 5'd0, 5'd0, 5'd3, 32'h3F80_0000, 1, 1'b0, 32'h3F80_0000, 1'b0);
    run_txn("fadd", 1, OP_FADD, 5'd1, 5'd2, 5'd4, 32'h0000_0007, 4, 1'b0, 32'h4040_0000, 1'b0);
    run_txn("fclt", 0, OP_FCLT, 5'd5, 5'd6, 5'd7, 32'h0, 2, 1'b1, 32'h0, 1'b0);
    repeat (3) step();
    check("hold_data1", 64'(bus.rsp_data1), 1);
    run_txn("get", 2, OP_GET, 5'd0, 5'd0, 5'd9, 32'h0, 1, 1'b0, 32'h1234_5678, 1'b0);
    repeat (2) step();
    check("hold_data32", 64'(bus.rsp_data32), 64'h1234_5678);

    // two continuous requesters from reset alternate
    do_reset();
    hold_mask = 3'b011;
    fpu_lat = 2;
    request(0, OP_FSUB, 5'd1, 5'd1, 5'd1, 32'h1);
    request(1, OP_FMUL, 5'd2, 5'd2, 5'd2, 32'h2);
    grants = 0;
    for (int c = 0; c < 100 && grants < 6; c++) begin
      step();
      if (bus.req_ready != '0) begin
        check($sformatf("alt_grant%0d", grants), 64'(bus.req_ready), 64'(oh(grants % 2)));
        grants++;
      end
    end
    check("alt_grants_seen", 64'(grants), 6);
    hold_mask = '0;
    drain(12);

    // reset in the 2nd ISSUE cycle drops the command and clears rr_ptr
    do_reset();
    run_txn("mov", 0, OP_MOV, 5'd1, 5'd0, 5'd2, 32'h0000_00A5, 1, 1'b1, 32'h0000_005A, 1'b0);
    fpu_lat = 10;
    request(1, OP_FMUL, 5'd3, 5'd4, 5'd5, 32'h11);
    n = 0;
    for (int c = 0; c < 20 && bus.req_ready == '0; c++) step();
    check("midrst_grant", 64'(bus.req_ready), 64'(oh(1)));
    for (int c = 0; c < 20 && n < 2; c++) begin
      step();
      if (bus.fpu_ready) n++;
    end
    check("midrst_issue_cycles", 64'(n), 2);
    rst = 1'b1;
    #1;
    check_zero("midrst");
    @(posedge clk);
    #1;
    rst = 1'b0;
    fpu_cnt = 0;
    bus.fpu_valid = 1'b0;
    model_ptr = 0;
    fpu_lat = 1;
    for (int c = 0; c < 5; c++) begin
      step();
      check($sformatf("midrst_no_rsp%0d", c), 64'(bus.rsp_valid), 0);
    end
    request(0, OP_FNEG, 5'd6, 5'd0, 5'd7, 32'h22);
    request(1, OP_FTOI, 5'd8, 5'd0, 5'd9, 32'h33);
    step();
    check("post_rst_grant", 64'(bus.req_ready), 64'(oh(0)));
    drain(10);

    // fpu_valid on the same cycle as the limit wins; then a silent fpu
    run_txn("coincide", 0, OP_ITOF, 5'd1, 5'd2, 5'd3, 32'h44, int'(TIMEOUT), 1'b1, 32'hCAFE_0001, 1'b0);
`ifdef FPU_ARB_TIMEOUT_EN
    run_txn("timeout", 1, OP_FMUL, 5'd4, 5'd5, 5'd6, 32'h55, 1000, 1'b1, 32'hDEAD_BEEF, 1'b1);
`else
    run_txn("long_wait", 1, OP_FMUL, 5'd4, 5'd5, 5'd6, 32'h55, 20, 1'b1, 32'hDEAD_BEEF, 1'b0);
`endif
    drain(4);

    // randomized traffic against the transaction model
    do_reset();
    owner = 0; t_g = 0; lat_cur = 1; issue_n = 0; n_txn = 0;
    exp_d1 = 1'b0; exp_d32 = '0;
    g_x1 = '0; g_x2 = '0; g_y = '0; g_op = '0; g_data = '0;
    for (int c = 0; c < 2000 && n_txn < 40; c++) begin
      for (int i = 0; i < int'(NREQ); i++)
        if (!bus.req_valid[i] && $urandom_range(0, 3) == 0)
          request(i, 6'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), $urandom);
      step();
      if (bus.req_ready != '0) begin
        e = rr_model(valid_at_edge, model_ptr);
        check("rnd_grant", 64'(bus.req_ready), (e < 0) ? 64'd0 : 64'(oh(e)));
        owner = (e < 0) ? 0 : e;
        g_x1 = c_x1[owner]; g_x2 = c_x2[owner]; g_y = c_y[owner];
        g_op = c_op[owner]; g_data = c_data[owner];
        t_g = cyc; issue_n = 0;
        lat_cur = int'($urandom_range(1, 5));
        fpu_lat = lat_cur;
        exp_d1 = 1'($urandom);
        exp_d32 = $urandom;
        bus.fpu_out_data1 = exp_d1;
        bus.fpu_out_data32 = exp_d32;
      end
      if (bus.fpu_ready) begin
        issue_n++;
        if (issue_n == 1)
          check("rnd_cmd", {bus.fpu_x1, bus.fpu_x2, bus.fpu_y, bus.fpu_operation, bus.fpu_in_data},
                {g_x1, g_x2, g_y, g_op, g_data});
      end
      if (bus.rsp_valid != '0) begin
        check("rnd_rsp_owner", 64'(bus.rsp_valid), 64'(oh(owner)));
        check("rnd_rsp_data", {bus.rsp_err, bus.rsp_data1, bus.rsp_data32}, {1'b0, exp_d1, exp_d32});
        check("rnd_latency", 64'(cyc - t_g + 1), 64'(lat_cur + 2));
        model_ptr = (owner + 1) % NREQ;
        n_txn++;
      end
    end
    check("rnd_txn_count", 64'(n_txn), 40);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
